// File: rtl/turtle_pkg.sv
// Shared widths, register/flag indices and instruction field encodings for the turtle core.
package turtle_pkg;

  localparam int unsigned DATA    = 8;
  localparam int unsigned INSTR   = 16;
  localparam int unsigned PC      = 12;
  localparam int unsigned REG_IDX = 4;

  localparam logic [REG_IDX-1:0] STATUS_IDX = 4'd15;

  localparam int unsigned ZERO     = 0;
  localparam int unsigned POSITIVE = 1;
  localparam int unsigned CARRY    = 2;
  localparam int unsigned OVERFLOW = 3;

  typedef enum logic [2:0] {
    OpAluReg = 3'b000,
    OpAluImm = 3'b001,
    OpRegMem = 3'b010,
    OpNop3   = 3'b011,
    OpJmp    = 3'b100,
    OpJmpr   = 3'b101,
    OpBranch = 3'b110,
    OpNop7   = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluXor = 3'b100,
    AluInv = 3'b101,
    AluShl = 3'b110,
    AluShr = 3'b111
  } alu_func_t;

  typedef enum logic [2:0] {
    RmGet   = 3'b000,
    RmPut   = 3'b001,
    RmLoad  = 3'b010,
    RmStore = 3'b011,
    RmSet   = 3'b100,
    RmNop5  = 3'b101,
    RmNop6  = 3'b110,
    RmNop7  = 3'b111
  } reg_mem_func_t;

  typedef enum logic [2:0] {
    BrZ      = 3'b000,
    BrNz     = 3'b001,
    BrP      = 3'b010,
    BrN      = 3'b011,
    BrCs     = 3'b100,
    BrCc     = 3'b101,
    BrNever6 = 3'b110,
    BrNever7 = 3'b111
  } branch_cond_t;

endpackage

// File: rtl/turtle_alu.sv
// turtle_alu: combinational 8-bit ALU producing a result plus Z/P/C/V flags.
module turtle_alu
  import turtle_pkg::*;
(
  input  logic [DATA-1:0] acc,
  input  logic [DATA-1:0] operand,
  input  alu_func_t       func,
  output logic [DATA-1:0] result,
  output logic            zero,
  output logic            positive,
  output logic            carry,
  output logic            overflow
);

  logic [DATA-1:0] op_b;
  logic [DATA:0]   sum;

  // SUB reuses the adder as acc + ~op + 1, so carry means "no borrow".
  assign op_b = (func == AluSub) ? ~operand : operand;
  assign sum  = {1'b0, acc} + {1'b0, op_b} + {{DATA{1'b0}}, (func == AluSub)};

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    unique case (func)
      AluAdd, AluSub: begin
        result   = sum[DATA-1:0];
        carry    = sum[DATA];
        overflow = (acc[DATA-1] == op_b[DATA-1]) && (sum[DATA-1] != acc[DATA-1]);
      end
      AluAnd: result = acc & operand;
      AluOr:  result = acc | operand;
      AluXor: result = acc ^ operand;
      AluInv: result = ~acc;
      AluShl: begin
        result = {acc[DATA-2:0], 1'b0};
        carry  = acc[DATA-1];
      end
      AluShr: begin
        result = {1'b0, acc[DATA-1:1]};
        carry  = acc[0];
      end
      default: result = '0;
    endcase
  end

  assign zero     = (result == '0);
  assign positive = ~result[DATA-1];

endmodule

// File: rtl/turtle_cpu.sv
// turtle_cpu: single-cycle 8-bit accumulator core with inline decode, register file and memories.
// Define TURTLE_MANUAL_CLK_EN to build the push-button single-step logic.
module turtle_cpu
  import turtle_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            manual_clk_sw,
  input  logic            pulse_clk_btn,
  output logic [PC-1:0]   pc_o,
  output logic [DATA-1:0] acc_o,
  output logic [3:0]      status_o
);

  logic [INSTR-1:0] imem [2**PC];
  logic [DATA-1:0]  dmem [2**DATA];
  logic [DATA-1:0]  regs [2**REG_IDX];

  logic [PC-1:0]   pc, pc_d;
  logic [DATA-1:0] acc, acc_d;
  logic            en;

`ifdef TURTLE_MANUAL_CLK_EN
  logic [1:0] sw_sync, btn_sync;
  logic       btn_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_sync  <= '0;
      btn_sync <= '0;
      btn_prev <= 1'b0;
    end else begin
      sw_sync  <= {sw_sync[0], manual_clk_sw};
      btn_sync <= {btn_sync[0], pulse_clk_btn};
      btn_prev <= btn_sync[1];
    end
  end

  // In step mode only the synchronized rising edge of the button advances the core.
  assign en = sw_sync[1] ? (btn_sync[1] & ~btn_prev) : 1'b1;
`else
  logic unused_step;
  assign unused_step = manual_clk_sw ^ pulse_clk_btn;
  assign en = 1'b1;
`endif

  logic [INSTR-1:0]   instr;
  opcode_t            opcode;
  alu_func_t          alu_func;
  reg_mem_func_t      rm_func;
  branch_cond_t       br_cond;
  logic [REG_IDX-1:0] rn;
  logic [DATA-1:0]    rval, alu_operand, alu_result;
  logic               flag_z, flag_p, flag_c, flag_v;

  assign instr       = imem[pc];
  assign opcode      = opcode_t'(instr[15:13]);
  assign alu_func    = alu_func_t'(instr[12:10]);
  assign rm_func     = reg_mem_func_t'(instr[12:10]);
  assign br_cond     = branch_cond_t'(instr[12:10]);
  assign rn          = instr[REG_IDX-1:0];
  assign rval        = regs[rn];
  assign alu_operand = (opcode == OpAluReg) ? rval : instr[DATA-1:0];

  turtle_alu u_alu (
    .acc      (acc),
    .operand  (alu_operand),
    .func     (alu_func),
    .result   (alu_result),
    .zero     (flag_z),
    .positive (flag_p),
    .carry    (flag_c),
    .overflow (flag_v)
  );

  logic               reg_we, dmem_we, taken;
  logic [REG_IDX-1:0] reg_waddr;
  logic [DATA-1:0]    reg_wdata;

  always_comb begin
    pc_d      = pc + 12'd1;
    acc_d     = acc;
    reg_we    = 1'b0;
    reg_waddr = rn;
    reg_wdata = acc;
    dmem_we   = 1'b0;
    taken     = 1'b0;
    unique case (opcode)
      OpAluReg, OpAluImm: begin
        acc_d               = alu_result;
        reg_we              = 1'b1;
        reg_waddr           = STATUS_IDX;
        reg_wdata           = '0;
        reg_wdata[ZERO]     = flag_z;
        reg_wdata[POSITIVE] = flag_p;
        reg_wdata[CARRY]    = flag_c;
        reg_wdata[OVERFLOW] = flag_v;
      end
      OpRegMem: begin
        unique case (rm_func)
          RmGet:   acc_d = rval;
          RmPut:   reg_we = 1'b1;
          RmLoad:  acc_d = dmem[rval];
          RmStore: dmem_we = 1'b1;
          RmSet:   acc_d = instr[DATA-1:0];
          default: ;
        endcase
      end
      OpJmp:  pc_d = instr[PC-1:0];
      OpJmpr: pc_d = pc + instr[PC-1:0];
      OpBranch: begin
        unique case (br_cond)
          BrZ:     taken = regs[STATUS_IDX][ZERO];
          BrNz:    taken = ~regs[STATUS_IDX][ZERO];
          BrP:     taken = regs[STATUS_IDX][POSITIVE];
          BrN:     taken = ~regs[STATUS_IDX][POSITIVE];
          BrCs:    taken = regs[STATUS_IDX][CARRY];
          BrCc:    taken = ~regs[STATUS_IDX][CARRY];
          default: taken = 1'b0;
        endcase
        if (taken) pc_d = pc + {{2{instr[9]}}, instr[9:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc  <= '0;
      acc <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (en) begin
      pc  <= pc_d;
      acc <= acc_d;
      if (reg_we) regs[reg_waddr] <= reg_wdata;
    end
  end

  // dmem is not reset; the reset_n term keeps an aborted STORE from landing.
  always_ff @(posedge clk) begin
    if (en && dmem_we && reset_n) dmem[rval] <= acc;
  end

  assign pc_o     = pc;
  assign acc_o    = acc;
  assign status_o = regs[STATUS_IDX][3:0];

endmodule

// File: tb/tb_turtle_cpu.sv
// Self-checking bench for turtle_cpu: directed programs plus a random program checked
// against an instruction-level reference model.
module tb_turtle_cpu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        manual_clk_sw = 1'b0;
  logic        pulse_clk_btn = 1'b0;
  logic [11:0] pc_o;
  logic [7:0]  acc_o;
  logic [3:0]  status_o;

  int n_checks = 0;
  int n_fail   = 0;

  turtle_cpu dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .manual_clk_sw (manual_clk_sw),
    .pulse_clk_btn (pulse_clk_btn),
    .pc_o          (pc_o),
    .acc_o         (acc_o),
    .status_o      (status_o)
  );

  always #5 clk = ~clk;

  // Reference model state.
  int m_pc, m_acc;
  int m_regs [16];
  int m_dmem [256];
  int m_imem [4096];

  function automatic int sx8(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  function automatic void model_step();
    int ins, op, f, n, a, b, res, c, v, sr, st, off, npc;
    bit taken;
    ins = m_imem[m_pc];
    op  = ins >> 13;
    f   = (ins >> 10) & 7;
    n   = ins & 15;
    a   = m_acc;
    npc = (m_pc + 1) % 4096;
    c = 0; v = 0; res = 0; taken = 0;
    case (op)
      0, 1: begin
        b = (op == 0) ? m_regs[n] : (ins & 255);
        case (f)
          0: begin res = a + b; c = (res > 255); sr = sx8(a) + sx8(b); v = (sr > 127 || sr < -128); end
          1: begin res = a + (255 - b) + 1; c = (res > 255); sr = sx8(a) - sx8(b);
                   v = (sr > 127 || sr < -128); end
          2: res = a & b;
          3: res = a | b;
          4: res = a ^ b;
          5: res = 255 - a;
          6: begin res = a * 2; c = a / 128; end
          default: begin res = a / 2; c = a % 2; end
        endcase
        res = res % 256;
        m_acc = res;
        m_regs[15] = v * 8 + c * 4 + ((res < 128) ? 2 : 0) + ((res == 0) ? 1 : 0);
      end
      2: begin
        case (f)
          0: m_acc = m_regs[n];
          1: m_regs[n] = m_acc;
          2: m_acc = m_dmem[m_regs[n]];
          3: m_dmem[m_regs[n]] = m_acc;
          4: m_acc = ins & 255;
          default: ;
        endcase
      end
      4: npc = ins & 4095;
      5: begin
        off = ins & 4095;
        if (off >= 2048) off -= 4096;
        npc = (m_pc + off + 4096) % 4096;
      end
      6: begin
        st = m_regs[15];
        case (f)
          0: taken = (st & 1) != 0;
          1: taken = (st & 1) == 0;
          2: taken = (st & 2) != 0;
          3: taken = (st & 2) == 0;
          4: taken = (st & 4) != 0;
          5: taken = (st & 4) == 0;
          default: taken = 0;
        endcase
        if (taken) begin
          off = ins & 1023;
          if (off >= 512) off -= 1024;
          npc = (m_pc + off + 4096) % 4096;
        end
      end
      default: ;
    endcase
    m_pc = npc;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    m_pc = 0;
    m_acc = 0;
    for (int i = 0; i < 16; i++) m_regs[i] = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic set_imem(input int a, input int v);
    dut.imem[a] = 16'(v);
    m_imem[a] = v;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 4096; i++) set_imem(i, 16'h6000);
  endtask

  task automatic test_reset();
    apply_reset();
    fill_nop();
    set_imem(0, 16'h5033);
    set_imem(1, 16'h440F);
    release_reset();
    tick(2);
    n_checks++;
    if (acc_o !== 8'h33) begin n_fail++; $display("FAIL put_r15_acc got %h exp 33", acc_o); end
    n_checks++;
    if (status_o !== 4'h3) begin n_fail++; $display("FAIL put_r15_status got %h exp 3", status_o); end
    n_checks++;
    if (dut.regs[15] !== 8'h33) begin n_fail++; $display("FAIL put_r15_hi got %h exp 33", dut.regs[15]); end
    apply_reset();
    n_checks++;
    if (pc_o !== 12'h000) begin n_fail++; $display("FAIL reset_pc got %h exp 000", pc_o); end
    n_checks++;
    if (acc_o !== 8'h00) begin n_fail++; $display("FAIL reset_acc got %h exp 00", acc_o); end
    n_checks++;
    if (status_o !== 4'h0) begin n_fail++; $display("FAIL reset_status got %h exp 0", status_o); end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (dut.regs[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_reg%0d got %h exp 00", i, dut.regs[i]);
      end
    end
  endtask

  task automatic test_alu_branch();
    // 5 + 0xFB wraps to zero with carry: Z, P, C set.
    apply_reset();
    fill_nop();
    set_imem(0, 16'h5005);
    set_imem(1, 16'h20FB);
    set_imem(2, 16'hC003);
    release_reset();
    tick(2);
    n_checks++;
    if (acc_o !== 8'h00) begin n_fail++; $display("FAIL add_wrap_acc got %h exp 00", acc_o); end
    n_checks++;
    if (status_o !== 4'h7) begin n_fail++; $display("FAIL add_wrap_status got %h exp 7", status_o); end
    n_checks++;
    if (pc_o !== 12'h002) begin n_fail++; $display("FAIL add_wrap_pc got %h exp 002", pc_o); end
    tick(1);
    n_checks++;
    if (pc_o !== 12'h005) begin n_fail++; $display("FAIL bz_taken_pc got %h exp 005", pc_o); end
    apply_reset();
    set_imem(2, 16'hC403);
    release_reset();
    tick(3);
    n_checks++;
    if (pc_o !== 12'h003) begin n_fail++; $display("FAIL bnz_not_taken_pc got %h exp 003", pc_o); end
    // 0x7F + 1 overflows into the sign bit.
    apply_reset();
    fill_nop();
    set_imem(0, 16'h507F);
    set_imem(1, 16'h2001);
    release_reset();
    tick(2);
    n_checks++;
    if (acc_o !== 8'h80) begin n_fail++; $display("FAIL add_ovf_acc got %h exp 80", acc_o); end
    n_checks++;
    if (status_o !== 4'h8) begin n_fail++; $display("FAIL add_ovf_status got %h exp 8", status_o); end
  endtask

  task automatic test_mem();
    apply_reset();
    fill_nop();
    set_imem(0, 16'h5010);
    set_imem(1, 16'h4402);
    set_imem(2, 16'h50AA);
    set_imem(3, 16'h4C02);
    set_imem(4, 16'h5000);
    set_imem(5, 16'h4802);
    release_reset();
    tick(6);
    n_checks++;
    if (dut.dmem[8'h10] !== 8'hAA) begin n_fail++; $display("FAIL store_dmem got %h exp AA", dut.dmem[8'h10]); end
    n_checks++;
    if (dut.regs[2] !== 8'h10) begin n_fail++; $display("FAIL put_r2 got %h exp 10", dut.regs[2]); end
    n_checks++;
    if (acc_o !== 8'hAA) begin n_fail++; $display("FAIL load_acc got %h exp AA", acc_o); end
  endtask

  task automatic test_jump();
    apply_reset();
    fill_nop();
    set_imem(0, 16'h8123);
    set_imem(12'h123, 16'hBFFF);
    set_imem(12'h122, 16'h8FFF);
    release_reset();
    tick(1);
    n_checks++;
    if (pc_o !== 12'h123) begin n_fail++; $display("FAIL jmp_pc got %h exp 123", pc_o); end
    tick(1);
    n_checks++;
    if (pc_o !== 12'h122) begin n_fail++; $display("FAIL jmpr_back_pc got %h exp 122", pc_o); end
    tick(1);
    n_checks++;
    if (pc_o !== 12'hFFF) begin n_fail++; $display("FAIL jmp_top_pc got %h exp FFF", pc_o); end
    tick(1);
    n_checks++;
    if (pc_o !== 12'h000) begin n_fail++; $display("FAIL pc_wrap got %h exp 000", pc_o); end
  endtask

  task automatic test_reset_abort();
    apply_reset();
    fill_nop();
    set_imem(0, 16'h4C00);
    dut.dmem[0] = 8'h5A;
    tick(3);
    n_checks++;
    if (dut.dmem[0] !== 8'h5A) begin n_fail++; $display("FAIL abort_store got %h exp 5A", dut.dmem[0]); end
    release_reset();
    tick(1);
    n_checks++;
    if (dut.dmem[0] !== 8'h00) begin n_fail++; $display("FAIL store_after_reset got %h exp 00", dut.dmem[0]); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 4096; i++) set_imem(i, int'($urandom_range(0, 65535)));
    for (int i = 0; i < 256; i++) begin
      m_dmem[i] = int'($urandom_range(0, 255));
      dut.dmem[i] = 8'(m_dmem[i]);
    end
    release_reset();
    for (int cyc = 0; cyc < 1500 && n_fail < 20; cyc++) begin
      model_step();
      tick(1);
      n_checks++;
      if (pc_o !== 12'(m_pc)) begin
        n_fail++; $display("FAIL rand_pc cyc %0d got %h exp %h", cyc, pc_o, m_pc);
      end
      n_checks++;
      if (acc_o !== 8'(m_acc)) begin
        n_fail++; $display("FAIL rand_acc cyc %0d got %h exp %h", cyc, acc_o, m_acc);
      end
      n_checks++;
      if (status_o !== 4'(m_regs[15] & 15)) begin
        n_fail++; $display("FAIL rand_status cyc %0d got %h exp %h", cyc, status_o, m_regs[15] & 15);
      end
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (dut.regs[i] !== 8'(m_regs[i])) begin
        n_fail++; $display("FAIL rand_reg%0d got %h exp %h", i, dut.regs[i], m_regs[i]);
      end
    end
    for (int i = 0; i < 256; i++) begin
      n_checks++;
      if (dut.dmem[i] !== 8'(m_dmem[i])) begin
        n_fail++; $display("FAIL rand_dmem%0d got %h exp %h", i, dut.dmem[i], m_dmem[i]);
      end
    end
  endtask

`ifdef TURTLE_MANUAL_CLK_EN
  task automatic test_step();
    // The switch synchronizer clears on reset, so two free-run edges follow release;
    // a temporary JMP 0 at address 1 parks the core at pc 0 before stepping begins.
    apply_reset();
    fill_nop();
    set_imem(1, 16'h8000);
    manual_clk_sw = 1'b1;
    release_reset();
    tick(2);
    n_checks++;
    if (pc_o !== 12'h000) begin n_fail++; $display("FAIL step_park_pc got %h exp 000", pc_o); end
    set_imem(1, 16'h6000);
    tick(100);
    n_checks++;
    if (pc_o !== 12'h000) begin n_fail++; $display("FAIL step_idle_pc got %h exp 000", pc_o); end
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      pulse_clk_btn = 1'b1;
      tick(2);
      n_checks++;
      if (pc_o !== 12'(p)) begin n_fail++; $display("FAIL step_early%0d got %h exp %h", p, pc_o, p); end
      tick(1);
      n_checks++;
      if (pc_o !== 12'(p + 1)) begin n_fail++; $display("FAIL step_edge%0d got %h exp %h", p, pc_o, p + 1); end
      tick(7);
      @(negedge clk);
      pulse_clk_btn = 1'b0;
      tick(10);
      n_checks++;
      if (pc_o !== 12'(p + 1)) begin n_fail++; $display("FAIL step_hold%0d got %h exp %h", p, pc_o, p + 1); end
    end
    n_checks++;
    if (pc_o !== 12'h003) begin n_fail++; $display("FAIL step_total_pc got %h exp 003", pc_o); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (pc_o !== 12'h000) begin n_fail++; $display("FAIL step_reset_pc got %h exp 000", pc_o); end
    manual_clk_sw = 1'b0;
    release_reset();
  endtask
`else
  task automatic test_step();
    // Without the step logic both inputs are ignored and the core free-runs.
    apply_reset();
    fill_nop();
    manual_clk_sw = 1'b1;
    release_reset();
    for (int i = 0; i < 20; i++) begin
      pulse_clk_btn = 1'($urandom_range(0, 1));
      tick(1);
    end
    n_checks++;
    if (pc_o !== 12'd20) begin n_fail++; $display("FAIL freerun_ignore_pc got %h exp 014", pc_o); end
    manual_clk_sw = 1'b0;
    pulse_clk_btn = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_alu_branch();
    test_mem();
    test_jump();
    test_reset_abort();
    test_random();
    test_step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
